// File: rtl/arb_rr_sched.sv
// Registered round-robin arbiter sharing one downstream req/ack channel among N requesters,
// with a static high-priority mask and hold-limit preemption of long-running owners.
module arb_rr_sched #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  hi,
  output logic [N-1:0]  ack_i,
  output logic          req_o,
  input  logic          ack_o,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_id
);

  localparam int HW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [N-1:0]  cand;
  logic [N-1:0]  others;
  logic [IW-1:0] winner;
  logic          found;
  logic          release_now;
  logic [IW-1:0] ptr_next;

  always_comb begin
    cand   = ((req_i & hi) != '0) ? (req_i & hi) : req_i;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      idx = (int'(ptr) + i) % N;
      if (!found && cand[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    others         = req_i;
    others[gnt_id] = 1'b0;
    release_now    = !req_i[gnt_id] ||
                     ((HOLD_MAX != 0) && (int'(hold_cnt) == HOLD_MAX - 1) && (others != '0));
    ptr_next       = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
  end

  // Downstream handshake passes straight through to the current owner only.
  always_comb begin
    ack_i = '0;
    req_o = 1'b0;
    if (state == GRANT) begin
      req_o         = req_i[gnt_id];
      ack_i[gnt_id] = ack_o & req_i[gnt_id];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            gnt_id   <= winner;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            gnt_vld  <= 1'b0;
            ptr      <= ptr_next;
            hold_cnt <= '0;
          end else if (int'(hold_cnt) != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_sched.sv
// Directed bench for arb_rr_sched (N=4, HOLD_MAX=4): per-cycle vector table plus a reset-mid-grant sequence.
module tb_arb_rr_sched;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_i;
  logic [N-1:0]  hi;
  logic [N-1:0]  ack_i;
  logic          req_o;
  logic          ack_o;
  logic          gnt_vld;
  logic [IW-1:0] gnt_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_rr_sched #(.N(N), .HOLD_MAX(4), .IW(IW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (req_i),
    .hi      (hi),
    .ack_i   (ack_i),
    .req_o   (req_o),
    .ack_o   (ack_o),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  typedef struct {
    logic          rstn;
    logic [N-1:0]  req;
    logic [N-1:0]  hi;
    logic          ack;
    logic          vld;
    logic [IW-1:0] id;
    logic          ro;
    logic [N-1:0]  ai;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] h, input logic a,
                     input logic v, input logic [1:0] id, input logic ro, input logic [3:0] ai,
                     input int reps = 1);
    vec_t t;
    t = '{rstn: r, req: rq, hi: h, ack: a, vld: v, id: id, ro: ro, ai: ai};
    for (int k = 0; k < reps; k++) tv.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // rstn, req, hi, ack_o | gnt_vld, gnt_id, req_o, ack_i   (outputs seen during that cycle)
    add(0, 4'hF, 4'h0, 1,  0, 0, 0, 4'h0, 3);  // held in reset
    add(1, 4'hF, 4'h0, 1,  0, 0, 0, 4'h0);     // first cycle out of reset is IDLE
    add(1, 4'hF, 4'h0, 1,  1, 0, 1, 4'h1);
    add(1, 4'hE, 4'h0, 1,  1, 0, 0, 4'h0);     // rotation 0,1,2,3
    add(1, 4'hE, 4'h0, 1,  0, 0, 0, 4'h0);
    add(1, 4'hE, 4'h0, 1,  1, 1, 1, 4'h2);
    add(1, 4'hC, 4'h0, 1,  1, 1, 0, 4'h0);
    add(1, 4'hC, 4'h0, 1,  0, 1, 0, 4'h0);
    add(1, 4'hC, 4'h0, 1,  1, 2, 1, 4'h4);
    add(1, 4'h8, 4'h0, 1,  1, 2, 0, 4'h0);
    add(1, 4'h8, 4'h0, 1,  0, 2, 0, 4'h0);
    add(1, 4'h8, 4'h0, 1,  1, 3, 1, 4'h8);
    add(1, 4'h0, 4'h0, 1,  1, 3, 0, 4'h0);
    add(1, 4'hF, 4'h0, 1,  0, 3, 0, 4'h0);     // ptr wrapped to 0
    add(1, 4'hF, 4'h0, 1,  1, 0, 1, 4'h1);
    add(1, 4'h0, 4'h0, 1,  1, 0, 0, 4'h0);
    add(1, 4'h0, 4'h0, 1,  0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h0, 1,  0, 0, 0, 4'h0);     // lone owner 1, never preempted
    add(1, 4'h2, 4'h0, 1,  1, 1, 1, 4'h2, 10);
    add(1, 4'h0, 4'h0, 1,  1, 1, 0, 4'h0);
    add(1, 4'h0, 4'h0, 1,  0, 1, 0, 4'h0);
    add(1, 4'h5, 4'h0, 1,  0, 1, 0, 4'h0);     // ptr=2 so owner 2 first, preempted after 4
    add(1, 4'h5, 4'h0, 1,  1, 2, 1, 4'h4, 4);
    add(1, 4'h5, 4'h0, 1,  0, 2, 0, 4'h0);
    add(1, 4'h5, 4'h0, 1,  1, 0, 1, 4'h1, 4);
    add(1, 4'h5, 4'h0, 1,  0, 0, 0, 4'h0);
    add(1, 4'h5, 4'h0, 0,  1, 2, 1, 4'h0);
    add(1, 4'h0, 4'h0, 0,  1, 2, 0, 4'h0);
    add(1, 4'h0, 4'h0, 0,  0, 2, 0, 4'h0);
    add(0, 4'h0, 4'h0, 0,  0, 2, 0, 4'h0);     // reset to bring ptr back to 0
    add(1, 4'hF, 4'h4, 1,  0, 0, 0, 4'h0);     // high priority 2 beats ptr=0
    add(1, 4'hF, 4'h4, 1,  1, 2, 1, 4'h4);
    add(1, 4'hB, 4'h4, 1,  1, 2, 0, 4'h0);
    add(1, 4'hB, 4'h4, 1,  0, 2, 0, 4'h0);
    add(1, 4'hB, 4'h4, 0,  1, 3, 1, 4'h0);     // ack gating
    add(1, 4'hB, 4'h4, 1,  1, 3, 1, 4'h8);
    add(1, 4'h3, 4'h4, 1,  1, 3, 0, 4'h0);
    add(1, 4'h3, 4'h4, 1,  0, 3, 0, 4'h0);
    add(1, 4'h3, 4'h4, 1,  1, 0, 1, 4'h1);
    add(1, 4'h2, 4'h4, 0,  1, 0, 0, 4'h0);
    add(1, 4'h0, 4'h4, 1,  0, 0, 0, 4'h0);     // ack_o toggles in IDLE
    add(1, 4'h0, 4'h4, 0,  0, 0, 0, 4'h0);

    rstn = 1'b0; req_i = 4'hF; hi = '0; ack_o = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      rstn  = tv[i].rstn;
      req_i = tv[i].req;
      hi    = tv[i].hi;
      ack_o = tv[i].ack;
      #3;
      check("gnt_vld", i, 32'(gnt_vld), 32'(tv[i].vld));
      check("gnt_id",  i, 32'(gnt_id),  32'(tv[i].id));
      check("req_o",   i, 32'(req_o),   32'(tv[i].ro));
      check("ack_i",   i, 32'(ack_i),   32'(tv[i].ai));
      @(posedge clk); #1;
    end

    // Reset during an active grant abandons it; ptr=1 here so requester 1 wins next.
    req_i = 4'h2; ack_o = 1'b1; hi = '0;
    for (int c = 0; c < 4 && !gnt_vld; c++) begin
      @(posedge clk); #1;
    end
    check("seq_grant_vld", 0, 32'(gnt_vld), 32'd1);
    check("seq_grant_id",  0, 32'(gnt_id),  32'd1);
    check("seq_grant_ack", 0, 32'(ack_i),   32'h2);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("seq_rst_vld",   1, 32'(gnt_vld), 32'd0);
    check("seq_rst_req_o", 1, 32'(req_o),   32'd0);
    check("seq_rst_ack",   1, 32'(ack_i),   32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("seq_regrant_vld", 2, 32'(gnt_vld), 32'd1);
    check("seq_regrant_id",  2, 32'(gnt_id),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
